// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback over the shared datapath and counts retired instructions.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALU_op,
  output logic             instr_done,
  output logic             bad_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath strobes, all decoded from the registered state
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_REG;
    ALU_op      = ALUOP_ADD;
    instr_done  = 1'b0;
    bad_op      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            bad_op  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        // A store retires in the cycle memory accepts it
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALU_op  = ALUOP_FUNCT;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_op      = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      // Unused encodings recover silently to FETCH
      default: state_d = S_FETCH;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           count_q <= '0;
    else if (instr_done) count_q <= count_q + CNT_W'(1);
  end

  assign instr_count = count_q;
  assign state       = 4'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench for multicycle_control against a per-instruction
// phase-list model of the control sequence.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, ALUSrcA, RegWrite, RegDst, instr_done, bad_op;
  logic [1:0]  PCSource, ALUSrcB, ALU_op;
  logic [31:0] instr_count;
  logic [3:0]  state;

  logic        d4_PCWrite, d4_PCWriteCond, d4_IorD, d4_MemRead, d4_MemWrite, d4_MemtoReg;
  logic        d4_IRWrite, d4_ALUSrcA, d4_RegWrite, d4_RegDst, d4_instr_done, d4_bad_op;
  logic [1:0]  d4_PCSource, d4_ALUSrcB, d4_ALU_op;
  logic [3:0]  d4_instr_count;
  logic [3:0]  d4_state;

  logic [15:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALU_op};

  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_cnt;
  int          rdy_q[$];
  bit          rand_rdy;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALU_op(ALU_op), .instr_done(instr_done), .bad_op(bad_op),
    .instr_count(instr_count), .state(state)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(d4_PCWrite), .PCWriteCond(d4_PCWriteCond), .IorD(d4_IorD),
    .MemRead(d4_MemRead), .MemWrite(d4_MemWrite), .MemtoReg(d4_MemtoReg),
    .IRWrite(d4_IRWrite), .ALUSrcA(d4_ALUSrcA), .RegWrite(d4_RegWrite),
    .RegDst(d4_RegDst), .PCSource(d4_PCSource), .ALUSrcB(d4_ALUSrcB),
    .ALU_op(d4_ALU_op), .instr_done(d4_instr_done), .bad_op(d4_bad_op),
    .instr_count(d4_instr_count), .state(d4_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Expected strobe vector for a state, straight from the per-state output table
  function automatic logic [15:0] exp_ctrl(input int st, input logic r);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
    logic [1:0] pcs, srcb, aop;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst} = '0;
    pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
    case (st)
      1:  begin mrd = 1'b1; srcb = 2'b01; irw = r; pcw = r; end
      2:  srcb = 2'b11;
      3:  begin srca = 1'b1; srcb = 2'b10; end
      4:  begin mrd = 1'b1; iord = 1'b1; end
      5:  begin m2r = 1'b1; rw = 1'b1; end
      6:  begin mwr = 1'b1; iord = 1'b1; end
      7:  begin srca = 1'b1; aop = 2'b10; end
      8:  begin rdst = 1'b1; rw = 1'b1; end
      9:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      10: begin pcw = 1'b1; pcs = 2'b10; end
      11: begin srca = 1'b1; srcb = 2'b10; end
      12: rw = 1'b1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst, pcs, srcb, aop};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
  endfunction

  function automatic logic next_rdy();
    if (rdy_q.size() != 0) return rdy_q.pop_front() != 0;
    if (rand_rdy) return $urandom_range(0, 2) != 0;
    return 1'b1;
  endfunction

  task automatic check_cycle(input int st, input logic r, input logic done_e, input logic bad_e);
    n_cmp++;
    if (state !== 4'(st)) begin
      n_bad++; $display("FAIL state: got %0d want %0d", state, st);
    end
    n_cmp++;
    if (ctrl !== exp_ctrl(st, r)) begin
      n_bad++; $display("FAIL ctrl st%0d: got %b want %b", st, ctrl, exp_ctrl(st, r));
    end
    n_cmp++;
    if (instr_done !== done_e) begin
      n_bad++; $display("FAIL instr_done st%0d: got %b want %b", st, instr_done, done_e);
    end
    n_cmp++;
    if (bad_op !== bad_e) begin
      n_bad++; $display("FAIL bad_op st%0d: got %b want %b", st, bad_op, bad_e);
    end
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++; $display("FAIL instr_count: got %0d want %0d", instr_count, exp_cnt);
    end
    n_cmp++;
    if (d4_instr_count !== exp_cnt[3:0] || d4_state !== 4'(st)) begin
      n_bad++; $display("FAIL cnt4: got cnt %0d st %0d want cnt %0d st %0d",
                        d4_instr_count, d4_state, exp_cnt[3:0], st);
    end
  endtask

  // Run one instruction through its phase list; abort_st stops at that state's negedge
  task automatic run_instr(input logic [5:0] op, input int abort_st);
    int ph[$];
    bit legal;
    legal = is_legal(op);
    ph = {1, 2};
    case (op)
      6'b100011: ph = {ph, 3, 4, 5};
      6'b101011: ph = {ph, 3, 6};
      6'b000000: ph = {ph, 7, 8};
      6'b000100: ph = {ph, 9};
      6'b000010: ph = {ph, 10};
      6'b001000: ph = {ph, 11, 12};
      default: ;
    endcase
    opcode = op;
    for (int i = 0; i < ph.size(); i++) begin
      bit advance;
      advance = 1'b0;
      while (!advance) begin
        logic r, done_e, bad_e;
        bit waits, last;
        r = next_rdy();
        mem_ready = r;
        @(negedge clk);
        waits  = (ph[i] == 1 || ph[i] == 4 || ph[i] == 6);
        last   = (i == ph.size() - 1);
        done_e = legal && last && (ph[i] != 6 || r);
        bad_e  = !legal && ph[i] == 2;
        check_cycle(ph[i], r, done_e, bad_e);
        if (ph[i] == abort_st) return;
        @(posedge clk); #1;
        if (done_e) exp_cnt = exp_cnt + 32'd1;
        advance = !waits || r;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (state !== 4'd0 || ctrl !== 16'd0 || instr_done !== 1'b0 || bad_op !== 1'b0) begin
      n_bad++;
      $display("FAIL %s outputs: got st %0d ctrl %b done %b bad %b want all 0",
               tag, state, ctrl, instr_done, bad_op);
    end
    n_cmp++;
    if (instr_count !== 32'd0 || d4_instr_count !== 4'd0 || d4_state !== 4'd0) begin
      n_bad++;
      $display("FAIL %s count: got %0d/%0d want 0", tag, instr_count, d4_instr_count);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_held");
    reset = 1'b0;
    #1;
    check_all_zero("idle_cycle");
    @(posedge clk); #1;
    exp_cnt = 32'd0;
  endtask

  task automatic test_reset();
    do_reset();
    rand_rdy = 1'b0;
    run_instr(6'b100011, 4);
    do_reset();
  endtask

  task automatic test_lw_zero_wait();
    run_instr(6'b100011, -1);
    n_cmp++;
    if (instr_count !== 32'd1) begin
      n_bad++; $display("FAIL lw_count: got %0d want 1", instr_count);
    end
  endtask

  task automatic test_lw_waits();
    // FETCH waits twice, DECODE/MEM_ADDR/MEM_WB see ready low, MEM_READ waits once
    rdy_q = {0, 0, 1, 0, 0, 0, 1, 0};
    run_instr(6'b100011, -1);
  endtask

  task automatic test_rtype_beq();
    run_instr(6'b000000, -1);
    run_instr(6'b000100, -1);
    n_cmp++;
    if (instr_count !== 32'd4) begin
      n_bad++; $display("FAIL rtype_beq_count: got %0d want 4", instr_count);
    end
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, -1);
    run_instr(6'b010101, -1);
    run_instr(6'b001000, -1);
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      run_instr(op, -1);
    end
    rand_rdy = 1'b0;
  endtask

  task automatic test_wrap_and_mid_reset();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      run_instr(6'b000010, -1);
      if (k == 14) begin
        n_cmp++;
        if (d4_instr_count !== 4'd15) begin
          n_bad++; $display("FAIL wrap_pre: got %0d want 15", d4_instr_count);
        end
      end
    end
    n_cmp++;
    if (d4_instr_count !== 4'd0 || instr_count !== 32'd16) begin
      n_bad++;
      $display("FAIL wrap: got %0d/%0d want 0/16", d4_instr_count, instr_count);
    end
    run_instr(6'b100011, -1);
    rdy_q = {1, 1, 1, 0};
    run_instr(6'b101011, 6);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (MemWrite !== 1'b0 || IorD !== 1'b0 || instr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got MemWrite %b IorD %b cnt %0d want 0 0 0",
               MemWrite, IorD, instr_count);
    end
    do_reset();
    run_instr(6'b101011, -1);
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    n_cmp     = 0;
    n_bad     = 0;
    exp_cnt   = 32'd0;
    rand_rdy  = 1'b0;
    #3;
    test_reset();
    test_lw_zero_wait();
    test_lw_waits();
    test_rtype_beq();
    test_illegal();
    test_random();
    test_wrap_and_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS core. It sequences the shared datapath (PC, IR/MDR, register file, the single ALU, unified memory) through fetch, decode, execute, memory and writeback, one instruction at a time. It drives `ALU_op` to the downstream ALU control decoder with the codes 00 = add, 01 = subtract and 10 = funct-decoded. It stalls on a memory-ready handshake and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26]; sampled only in DECODE and MEM_ADDR.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst` out 1: datapath strobes and selects.
- `PCSource` out 2: PC source select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUSrcB` out 2: ALU operand B select. 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `ALU_op` out 2: code to the ALU control decoder.
- `instr_done` out 1: one-cycle pulse in the final cycle of each legal instruction.
- `bad_op` out 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `instr_count` out CNT_W: number of retired instructions.
- `state` out 4: current state encoding, for debug.

## Operation
- **State encodings:** IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12.
- **Default outputs:** any output not listed for a state is 0.
- **Supported opcodes:** R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.

Per-state outputs and transitions:
- **IDLE:** all outputs 0. Next state FETCH.
- **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=00, PCSource=00. IRWrite=PCWrite=`mem_ready`. Stay while `mem_ready`=0; otherwise go to DECODE.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALU_op=00. Next state by opcode:
  - lw or sw → MEM_ADDR
  - R-type → EXECUTE
  - beq → BRANCH
  - j → JUMP
  - addi → ADDI_EX
  - anything else → FETCH, with `bad_op`=1, no `instr_done`, and no count.
- **MEM_ADDR:** ALUSrcA=1, ALUSrcB=10, ALU_op=00. lw → MEM_READ; sw → MEM_WRITE.
- **MEM_READ:** MemRead=1, IorD=1. Wait for `mem_ready`, then go to MEM_WB.
- **MEM_WB:** RegDst=0, MemtoReg=1, RegWrite=1. Done; next state FETCH.
- **MEM_WRITE:** MemWrite=1, IorD=1. Held until `mem_ready`. Done and go to FETCH in the cycle `mem_ready`=1.
- **EXECUTE:** ALUSrcA=1, ALUSrcB=00, ALU_op=10. Next state R_WB.
- **R_WB:** RegDst=1, RegWrite=1. Done; next state FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALU_op=01, PCWriteCond=1, PCSource=01. Done; next state FETCH.
- **JUMP:** PCWrite=1, PCSource=10. Done; next state FETCH.
- **ADDI_EX:** ALUSrcA=1, ALUSrcB=10, ALU_op=00. Next state ADDI_WB.
- **ADDI_WB:** RegDst=0, MemtoReg=0, RegWrite=1. Done; next state FETCH.

Retirement and recovery:
- **"Done"** means `instr_done`=1 combinationally in that cycle. `instr_count` increments on the same rising edge and wraps modulo 2^CNT_W.
- **Unused encodings 13–15:** all outputs 0; next state FETCH. No pulses.

## Timing
- **Reset values:** while `reset`=1, the state is IDLE and every output is 0, including `instr_count`=0 and `state`=0.
- **After reset release:** one IDLE cycle, then FETCH.
- **Reset mid-instruction:** immediate return to IDLE. No partial strobes after the asserting edge. `instr_count` is cleared.
- **Output type:** all outputs are combinational from the registered state. The only exceptions are IRWrite/PCWrite in FETCH and `instr_done` in MEM_WRITE, which are also qualified by `mem_ready`.
- **Cycles per instruction with zero wait states:** lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- **Wait cycles:** each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- **Illegal opcode:** costs 2 cycles (FETCH, DECODE) and does not retire.
- **Unused ready:** `mem_ready` is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.
- **IR stability:** IR changes only on FETCH with `mem_ready`, so `opcode` is stable from DECODE through the end of the instruction.

## Structure
- **Package `mips_pkg`:**
  - `state_t` enum with the encodings above
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`)
  - ALU_op constants (`ALUOP_ADD`=00, `ALUOP_SUB`=01, `ALUOP_FUNCT`=10)
  - PCSource and ALUSrcB select constants
- **Single module, no sub-module:**
  - one state register
  - one combinational next-state/output block
  - one counter register
- The ALU control decoder stays outside this block.

## Test plan
- **Reset:** assert `reset` mid-cycle → all outputs 0 and `state`=0 asynchronously. Release → `state` 0 for 1 cycle, then 1.
- **lw, zero wait:** `mem_ready`=1, `opcode`=100011 → states 1,2,3,4,5,1. `instr_done` only in state 5. `instr_count` 0→1.
- **lw with waits:** `mem_ready` low 2 cycles in FETCH and 1 cycle in MEM_READ → 8 cycles. IRWrite/PCWrite high only in the ready FETCH cycle.
- **R-type then beq:** EXECUTE shows ALU_op=10. BRANCH shows ALU_op=01, PCWriteCond=1, PCSource=01. `instr_count`=2 after 7 cycles.
- **Illegal opcode 111111:** `bad_op`=1 in DECODE, next state FETCH, `instr_count` unchanged.
- **Wrap and mid-instruction reset:** CNT_W=4, 16 j instructions → `instr_count` wraps 15→0. Reset asserted in MEM_WRITE → MemWrite drops immediately and `instr_count`=0.
